// File: rtl/mf_pkg.sv
// Shared constants, FSM state type and pixel/clamp helpers for the median-filter scan block.
package mf_pkg;

  localparam int COORD_W = 8;
  localparam int PIX_W   = 8;
  localparam int PIPE    = 3;

  localparam logic [COORD_W-1:0] C_ZERO = {COORD_W{1'b0}};
  localparam logic [COORD_W-1:0] C_ONE  = {{(COORD_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } mf_state_e;

  // Synthetic image: (x*16 + y) mod 256, the shift drops the bits that wrap.
  function automatic logic [PIX_W-1:0] pix(input logic [COORD_W-1:0] x,
                                           input logic [COORD_W-1:0] y);
    return (x << 3'd4) + y;
  endfunction

  // Signed neighbour coordinate clamped into [0, hi]; one extra bit keeps -1 and 255 distinct.
  function automatic logic [COORD_W-1:0] clamp(input logic signed [COORD_W:0] v,
                                               input logic [COORD_W-1:0]      hi);
    logic [COORD_W-1:0] res;
    if (v[COORD_W]) begin
      res = C_ZERO;
    end else if (v > $signed({1'b0, hi})) begin
      res = hi;
    end else begin
      res = v[COORD_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/mf_block_median_scan_if.sv
// Request/sample bus between the scan block (master) and its downstream consumer (slave).
interface mf_block_median_scan_if;
  import mf_pkg::*;

  logic               enable;
  logic               Nxt_block_sig;
  logic [COORD_W-1:0] height;
  logic [COORD_W-1:0] width;
  logic [COORD_W-1:0] addr_x0;
  logic [COORD_W-1:0] addr_y0;
  logic [PIX_W-1:0]   gdata;
  logic               Gvector_sig;

  modport master (
    input  enable, Nxt_block_sig, height, width,
    output addr_x0, addr_y0, gdata, Gvector_sig
  );

  modport slave (
    output enable, Nxt_block_sig, height, width,
    input  addr_x0, addr_y0, gdata, Gvector_sig
  );

endinterface

// File: rtl/mf_median9.sv
// Two-stage 3x3 median: rows sorted first, then median of (max of mins, median of mids, min of maxes).
module mf_median9
  import mf_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [8:0][PIX_W-1:0] i_pix,
  output logic                  o_valid,
  output logic [PIX_W-1:0]      o_med
);

  function automatic logic [PIX_W-1:0] min2(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [PIX_W-1:0] max2(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return (a < b) ? b : a;
  endfunction

  function automatic logic [PIX_W-1:0] med3(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                            input logic [PIX_W-1:0] c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  logic                  r_v1;
  logic [2:0][PIX_W-1:0] r_lo;
  logic [2:0][PIX_W-1:0] r_mid;
  logic [2:0][PIX_W-1:0] r_hi;
  logic [PIX_W-1:0]      w_lo_max;
  logic [PIX_W-1:0]      w_mid_med;
  logic [PIX_W-1:0]      w_hi_min;

  // Stage 1: sort each row of the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_lo  <= '0;
      r_mid <= '0;
      r_hi  <= '0;
    end else begin
      r_v1 <= i_valid;
      if (i_valid) begin
        for (int r = 0; r < 3; r++) begin
          r_lo[r]  <= min2(min2(i_pix[3*r], i_pix[3*r+1]), i_pix[3*r+2]);
          r_mid[r] <= med3(i_pix[3*r], i_pix[3*r+1], i_pix[3*r+2]);
          r_hi[r]  <= max2(max2(i_pix[3*r], i_pix[3*r+1]), i_pix[3*r+2]);
        end
      end
    end
  end

  assign w_lo_max  = max2(max2(r_lo[0], r_lo[1]), r_lo[2]);
  assign w_mid_med = med3(r_mid[0], r_mid[1], r_mid[2]);
  assign w_hi_min  = min2(min2(r_hi[0], r_hi[1]), r_hi[2]);

  // Stage 2: final median; value holds between samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_med   <= '0;
    end else begin
      o_valid <= r_v1;
      if (r_v1) begin
        o_med <= med3(w_lo_max, w_mid_med, w_hi_min);
      end
    end
  end

endmodule

// File: rtl/mf_block_median_scan.sv
// Raster-scans an H x W block of a synthetic image and streams the clamped 3x3 median per coordinate.
module mf_block_median_scan
  import mf_pkg::*;
(
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   Slow_clk,
  mf_block_median_scan_if.master bus
);

  mf_state_e             r_state;
  logic [COORD_W-1:0]    r_x, r_y, r_h, r_w;
  logic                  r_iss_v, r_f_v, r_m1_v;
  logic [COORD_W-1:0]    r_iss_x, r_iss_y, r_f_x, r_f_y, r_m1_x, r_m1_y, r_ox, r_oy;
  logic [8:0][PIX_W-1:0] r_win;

  logic                  w_unused;
  logic                  w_start, w_issue, w_last_col, w_last, w_busy;
  logic [COORD_W-1:0]    w_cur_x, w_cur_y, w_lim_w, w_lim_h, w_nx, w_ny;
  logic [2:0][COORD_W-1:0] w_col, w_row;
  logic [8:0][PIX_W-1:0] w_win;
  logic                  w_med_v;
  logic [PIX_W-1:0]      w_med;

  assign w_unused = Slow_clk;
  assign w_busy   = r_iss_v | r_f_v | r_m1_v;

  // The start edge issues (0,0) itself, so the first sample lands PIPE edges after the start
  always_comb begin
    w_start = (r_state == ST_IDLE) && bus.enable && bus.Nxt_block_sig;
    if (r_state == ST_IDLE) begin
      w_cur_x = C_ZERO;
      w_cur_y = C_ZERO;
      w_lim_w = bus.width - C_ONE;
      w_lim_h = bus.height - C_ONE;
      w_issue = w_start && (bus.width != C_ZERO) && (bus.height != C_ZERO);
    end else begin
      w_cur_x = r_x;
      w_cur_y = r_y;
      w_lim_w = r_w - C_ONE;
      w_lim_h = r_h - C_ONE;
      w_issue = (r_state == ST_SCAN) && bus.enable;
    end
    w_last_col = (w_cur_x == w_lim_w);
    w_last     = w_last_col && (w_cur_y == w_lim_h);
    if (w_last_col) begin
      w_nx = C_ZERO;
      w_ny = w_cur_y + C_ONE;
    end else begin
      w_nx = w_cur_x + C_ONE;
      w_ny = w_cur_y;
    end
  end

  // Scan FSM, raster counters and issue register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_x     <= C_ZERO;
      r_y     <= C_ZERO;
      r_h     <= C_ZERO;
      r_w     <= C_ZERO;
      r_iss_v <= 1'b0;
      r_iss_x <= C_ZERO;
      r_iss_y <= C_ZERO;
    end else begin
      r_iss_v <= w_issue;
      if (w_issue) begin
        r_iss_x <= w_cur_x;
        r_iss_y <= w_cur_y;
        r_x     <= w_nx;
        r_y     <= w_ny;
      end
      if (w_start) begin
        r_h <= bus.height;
        r_w <= bus.width;
      end
      case (r_state)
        ST_IDLE:  if (w_issue) r_state <= w_last ? ST_DRAIN : ST_SCAN;
        ST_SCAN:  if (w_issue && w_last) r_state <= ST_DRAIN;
        ST_DRAIN: if (!w_busy) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Edge-replicated 3x3 neighbourhood of the issued coordinate
  always_comb begin
    w_col    = '0;
    w_row    = '0;
    w_win    = '0;
    w_col[0] = clamp($signed({1'b0, r_iss_x}) - $signed({1'b0, C_ONE}), r_w - C_ONE);
    w_col[1] = r_iss_x;
    w_col[2] = clamp($signed({1'b0, r_iss_x}) + $signed({1'b0, C_ONE}), r_w - C_ONE);
    w_row[0] = clamp($signed({1'b0, r_iss_y}) - $signed({1'b0, C_ONE}), r_h - C_ONE);
    w_row[1] = r_iss_y;
    w_row[2] = clamp($signed({1'b0, r_iss_y}) + $signed({1'b0, C_ONE}), r_h - C_ONE);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w_win[3*r+c] = pix(w_col[c], w_row[r]);
      end
    end
  end

  // Window-fetch stage plus the coordinate side-pipe that tracks the median stages
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_f_v  <= 1'b0;
      r_m1_v <= 1'b0;
      r_win  <= '0;
      r_f_x  <= C_ZERO;
      r_f_y  <= C_ZERO;
      r_m1_x <= C_ZERO;
      r_m1_y <= C_ZERO;
      r_ox   <= C_ZERO;
      r_oy   <= C_ZERO;
    end else begin
      r_f_v  <= r_iss_v;
      r_m1_v <= r_f_v;
      if (r_iss_v) begin
        r_win <= w_win;
        r_f_x <= r_iss_x;
        r_f_y <= r_iss_y;
      end
      if (r_f_v) begin
        r_m1_x <= r_f_x;
        r_m1_y <= r_f_y;
      end
      if (r_m1_v) begin
        r_ox <= r_m1_x;
        r_oy <= r_m1_y;
      end
    end
  end

  mf_median9 u_median9 (
    .clk     (CLK),
    .rst_n   (reset),
    .i_valid (r_f_v),
    .i_pix   (r_win),
    .o_valid (w_med_v),
    .o_med   (w_med)
  );

  assign bus.addr_x0     = r_ox;
  assign bus.addr_y0     = r_oy;
  assign bus.gdata       = w_med;
  assign bus.Gvector_sig = w_med_v;

endmodule

// File: tb/tb_mf_block_median_scan.sv
// Scenario bench for mf_block_median_scan: directed edge cases plus randomized blocks checked
// against a sort-based 3x3 median model of the synthetic image.
module tb_mf_block_median_scan;
  import mf_pkg::*;

  logic CLK      = 1'b0;
  logic reset    = 1'b0;
  logic Slow_clk = 1'b0;
  int   total    = 0;
  int   bad      = 0;

  mf_block_median_scan_if bus();

  mf_block_median_scan dut (
    .CLK      (CLK),
    .reset    (reset),
    .Slow_clk (Slow_clk),
    .bus      (bus)
  );

  always #5  CLK = ~CLK;
  always #13 Slow_clk = ~Slow_clk;

  // Reference: gather the clamped neighbourhood, sort it, take the 5th smallest.
  function automatic int ref_med(input int x, input int y, input int w, input int h);
    int v[9];
    int k, t, cx, cy;
    k = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        cx = x + dx; if (cx < 0) cx = 0; if (cx > w - 1) cx = w - 1;
        cy = y + dy; if (cy < 0) cy = 0; if (cy > h - 1) cy = h - 1;
        v[k] = (cx * 16 + cy) % 256;
        k++;
      end
    end
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    return v[4];
  endfunction

  task automatic start_block(input int h, input int w);
    @(negedge CLK);
    bus.height = 8'(h); bus.width = 8'(w);
    bus.enable = 1'b1; bus.Nxt_block_sig = 1'b1;
    @(posedge CLK); #1;
    bus.Nxt_block_sig = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.enable = 1'b1; bus.Nxt_block_sig = 1'b1;
    bus.height = 8'd3; bus.width = 8'd3;
    repeat (3) @(posedge CLK); #1;
    total++; if (bus.Gvector_sig !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.Gvector_sig); end
    total++; if (int'(bus.addr_x0) !== 0) begin bad++; $display("FAIL reset_x got=%0d want=0", bus.addr_x0); end
    total++; if (int'(bus.addr_y0) !== 0) begin bad++; $display("FAIL reset_y got=%0d want=0", bus.addr_y0); end
    total++; if (int'(bus.gdata) !== 0) begin bad++; $display("FAIL reset_gdata got=%0d want=0", bus.gdata); end
  endtask

  task automatic test_basic();
    int exp_g[9] = '{1, 16, 32, 2, 17, 32, 2, 18, 33};
    int n = 0;
    int first = -1;
    @(negedge CLK); reset = 1'b1;
    @(posedge CLK); #1; bus.Nxt_block_sig = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge CLK); #1;
      if (bus.Gvector_sig === 1'b1) begin
        if (first < 0) first = cyc;
        if (n < 9) begin
          total++; if (int'(bus.addr_x0) !== n % 3 || int'(bus.addr_y0) !== n / 3) begin
            bad++; $display("FAIL basic_coord n=%0d got=(%0d,%0d) want=(%0d,%0d)", n, bus.addr_x0, bus.addr_y0, n % 3, n / 3);
          end
          total++; if (int'(bus.gdata) !== exp_g[n]) begin
            bad++; $display("FAIL basic_gdata n=%0d got=%0d want=%0d", n, bus.gdata, exp_g[n]);
          end
        end
        n++;
      end
    end
    total++; if (first !== 3) begin bad++; $display("FAIL basic_latency got=%0d want=3", first); end
    total++; if (n !== 9) begin bad++; $display("FAIL basic_count got=%0d want=9", n); end
  endtask

  task automatic test_enable_gap();
    int n = 0;
    start_block(3, 3);
    for (int cyc = 1; cyc <= 25; cyc++) begin
      @(posedge CLK); #1;
      if (bus.Gvector_sig === 1'b1) begin
        if (n < 9) begin
          total++; if (cyc !== ((n < 4) ? n + 3 : n + 7)) begin
            bad++; $display("FAIL gap_timing n=%0d got=%0d want=%0d", n, cyc, (n < 4) ? n + 3 : n + 7);
          end
          total++; if (int'(bus.addr_x0) !== n % 3 || int'(bus.addr_y0) !== n / 3 ||
                       int'(bus.gdata) !== ref_med(n % 3, n / 3, 3, 3)) begin
            bad++; $display("FAIL gap_sample n=%0d got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)", n, bus.addr_x0,
                            bus.addr_y0, bus.gdata, n % 3, n / 3, ref_med(n % 3, n / 3, 3, 3));
          end
        end
        n++;
      end
      if (cyc == 3) bus.enable = 1'b0;
      if (cyc == 7) bus.enable = 1'b1;
    end
    total++; if (n !== 9) begin bad++; $display("FAIL gap_count got=%0d want=9", n); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int last = 0;
    @(negedge CLK);
    bus.height = 8'd1; bus.width = 8'd2; bus.enable = 1'b1; bus.Nxt_block_sig = 1'b1;
    for (int cyc = 0; cyc <= 45; cyc++) begin
      @(posedge CLK); #1;
      if (bus.Gvector_sig === 1'b1) begin
        total++; if (int'(bus.addr_x0) !== n % 2 || int'(bus.addr_y0) !== 0 ||
                     int'(bus.gdata) !== ((n % 2 == 1) ? 16 : 0)) begin
          bad++; $display("FAIL b2b_sample n=%0d got=(%0d,%0d,%0d) want=(%0d,0,%0d)", n, bus.addr_x0,
                          bus.addr_y0, bus.gdata, n % 2, (n % 2 == 1) ? 16 : 0);
        end
        if (n % 2 == 1) begin
          total++; if (cyc - last !== 1) begin bad++; $display("FAIL b2b_pair n=%0d got=%0d want=1", n, cyc - last); end
        end else if (n > 0) begin
          total++; if (cyc - last - 1 < 4) begin bad++; $display("FAIL b2b_gap n=%0d got=%0d want>=4", n, cyc - last - 1); end
        end
        last = cyc;
        n++;
      end
    end
    bus.Nxt_block_sig = 1'b0;
    repeat (10) @(posedge CLK);
    total++; if (n < 12) begin bad++; $display("FAIL b2b_count got=%0d want>=12", n); end
  endtask

  task automatic test_zero();
    int n = 0;
    int first = -1;
    @(negedge CLK); reset = 1'b0; bus.Nxt_block_sig = 1'b0;
    repeat (2) @(negedge CLK); reset = 1'b1;
    @(negedge CLK);
    bus.height = 8'd0; bus.width = 8'd5; bus.enable = 1'b1; bus.Nxt_block_sig = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge CLK); #1;
      if (bus.Gvector_sig === 1'b1) n++;
    end
    total++; if (n !== 0) begin bad++; $display("FAIL zero_pulses got=%0d want=0", n); end
    total++; if (int'(bus.addr_x0) !== 0 || int'(bus.addr_y0) !== 0 || int'(bus.gdata) !== 0) begin
      bad++; $display("FAIL zero_outputs got=(%0d,%0d,%0d) want=(0,0,0)", bus.addr_x0, bus.addr_y0, bus.gdata);
    end
    @(negedge CLK); bus.height = 8'd1; bus.width = 8'd1;
    @(posedge CLK); #1; bus.Nxt_block_sig = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge CLK); #1;
      if (bus.Gvector_sig === 1'b1) begin
        if (first < 0) first = cyc;
        n++;
      end
    end
    total++; if (first !== 3) begin bad++; $display("FAIL zero_then_1x1_latency got=%0d want=3", first); end
    total++; if (n !== 1) begin bad++; $display("FAIL zero_then_1x1_count got=%0d want=1", n); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int first = -1;
    start_block(3, 3);
    repeat (4) @(posedge CLK);
    #3; reset = 1'b0; #1;
    total++; if (bus.Gvector_sig !== 1'b0 || int'(bus.addr_x0) !== 0 || int'(bus.addr_y0) !== 0 ||
                 int'(bus.gdata) !== 0) begin
      bad++; $display("FAIL midreset_clear got=(%b,%0d,%0d,%0d) want=(0,0,0,0)", bus.Gvector_sig,
                      bus.addr_x0, bus.addr_y0, bus.gdata);
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK); reset = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge CLK); #1;
      if (bus.Gvector_sig === 1'b1) n++;
    end
    total++; if (n !== 0) begin bad++; $display("FAIL midreset_quiet got=%0d want=0", n); end
    start_block(3, 3);
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(posedge CLK); #1;
      if (bus.Gvector_sig === 1'b1) begin
        if (first < 0) begin
          first = cyc;
          total++; if (int'(bus.addr_x0) !== 0 || int'(bus.addr_y0) !== 0 || int'(bus.gdata) !== 1) begin
            bad++; $display("FAIL midreset_restart got=(%0d,%0d,%0d) want=(0,0,1)", bus.addr_x0, bus.addr_y0, bus.gdata);
          end
        end
        n++;
      end
    end
    total++; if (first !== 3) begin bad++; $display("FAIL midreset_latency got=%0d want=3", first); end
    total++; if (n !== 9) begin bad++; $display("FAIL midreset_count got=%0d want=9", n); end
  endtask

  // Random block sizes, random enable stalls and junk size changes mid-block.
  task automatic run_block_checked(input int h, input int w, input int budget, input bit stall);
    int n = 0;
    int extra = 0;
    int ex, ey;
    start_block(h, w);
    for (int cyc = 1; cyc <= budget && extra < 8; cyc++) begin
      if (stall) begin
        bus.enable = ($urandom_range(0, 3) != 0);
        bus.height = 8'($urandom_range(0, 255));
        bus.width  = 8'($urandom_range(0, 255));
      end
      @(posedge CLK); #1;
      if (bus.Gvector_sig === 1'b1) begin
        ex = n % w; ey = n / w;
        total++; if (n >= h * w) begin
          bad++; $display("FAIL rand_extra h=%0d w=%0d n=%0d got=1 want=0", h, w, n);
        end else if (int'(bus.addr_x0) !== ex || int'(bus.addr_y0) !== ey ||
                     int'(bus.gdata) !== ref_med(ex, ey, w, h)) begin
          bad++; $display("FAIL rand_sample h=%0d w=%0d got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)", h, w,
                          bus.addr_x0, bus.addr_y0, bus.gdata, ex, ey, ref_med(ex, ey, w, h));
        end
        n++;
      end
      if (n >= h * w) extra++;
    end
    bus.enable = 1'b1;
    total++; if (n !== h * w) begin bad++; $display("FAIL rand_count h=%0d w=%0d got=%0d want=%0d", h, w, n, h * w); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      run_block_checked($urandom_range(1, 5), $urandom_range(1, 6), 300, 1'b1);
    end
  endtask

  task automatic test_wide();
    run_block_checked(2, 255, 560, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_enable_gap();
    test_back_to_back();
    test_zero();
    test_reset_mid();
    test_random();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
